// File: rtl/dds_phase_accum.sv
// DDS phase accumulator (NCO) with handshaked FTW load and wrap strobe.
// Optional LFSR truncation dither: define DDS_PHASE_DITHER_EN.
module dds_phase_accum #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               sync_mode,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] poff,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_active;
  logic [ACC_W-1:0] ftw_pend;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             xfer;
  logic [ACC_W-1:0] acc_d;

  assign sum   = {1'b0, acc} + {1'b0, ftw_active};
  assign carry = en & sum[ACC_W];
  assign xfer  = (state == PEND) &
                 (~sync_mode | (carry & ~phase_clr));

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0]       lfsr;
  logic [ACC_W+15:0] lfsr_x;
  logic [ACC_W-1:0]  dmask;

  assign lfsr_x = {{ACC_W{1'b0}}, lfsr};
  assign dmask  = (ACC_W'(1) << (ACC_W - PHASE_W)) - ACC_W'(1);
  // Carry out of the dithered sum is dropped on purpose.
  assign acc_d  = acc + (lfsr_x[ACC_W-1:0] & dmask);

  // Fibonacci LFSR, taps 16,14,13,11, stepping while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (en) begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign acc_d = acc;
`endif

  // Accumulator, wrap strobe and offset phase output.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      wrap  <= 1'b0;
      phase <= '0;
    end else begin
      if (phase_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
      end
      wrap  <= carry & ~phase_clr;
      phase <= acc_d[ACC_W-1 -: PHASE_W] + poff;
    end
  end

  // FTW load FSM; ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ftw_pend   <= '0;
      ftw_active <= '0;
      ftw_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (ftw_valid) begin
            ftw_pend  <= ftw_in;
            state     <= PEND;
            ftw_ready <= 1'b0;
          end
        end
        PEND: begin
          if (xfer) begin
            ftw_active <= ftw_pend;
            state      <= IDLE;
            ftw_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ftw_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed testbench for dds_phase_accum (default parameters,
// dither disabled).
module tb_dds_phase_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        phase_clr;
  logic        sync_mode;
  logic [23:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [13:0] poff;
  logic [13:0] phase;
  logic        wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dds_phase_accum dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase_clr (phase_clr),
    .sync_mode (sync_mode),
    .ftw_in    (ftw_in),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .poff      (poff),
    .phase     (phase),
    .wrap      (wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; phase_clr = 1'b0;
    sync_mode = 1'b0; ftw_in = '0; ftw_valid = 1'b0;
    poff = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_now(input logic [23:0] w);
    ftw_in = w; ftw_valid = 1'b1; sync_mode = 1'b0;
    tick();
    ftw_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (phase !== 14'h0) begin
      fails++;
      $display("FAIL reset_phase got %h exp 0000", phase);
    end
    tests++;
    if (wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_wrap got %b exp 0", wrap);
    end
    tests++;
    if (ftw_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", ftw_ready);
    end
  endtask

  task automatic test_small_ftw();
    int n;
    logic [13:0] exp_ph;
    do_reset();
    en = 1'b1;
    ftw_in = 24'h000400; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    tests++;
    if (ftw_ready !== 1'b0) begin
      fails++;
      $display("FAIL small_ready_low got %b exp 0", ftw_ready);
    end
    tick();
    tests++;
    if (ftw_ready !== 1'b1) begin
      fails++;
      $display("FAIL small_ready_back got %b exp 1", ftw_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_ph = 14'(i);
      tests++;
      if (phase !== exp_ph) begin
        fails++;
        $display("FAIL small_step%0d got %h exp %h",
                 i, phase, exp_ph);
      end
    end
    n = 0;
    while (!wrap && n < 20000) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 16381) begin
      fails++;
      $display("FAIL small_wrap_cycles got %0d exp 16381", n);
    end
    tests++;
    if (phase !== 14'h3FFF) begin
      fails++;
      $display("FAIL small_wrap_phase got %h exp 3fff", phase);
    end
    tick();
    tests++;
    if (wrap !== 1'b0) begin
      fails++;
      $display("FAIL small_wrap_pulse got %b exp 0", wrap);
    end
  endtask

  task automatic test_big_ftw();
    logic [13:0] exp_ph [8];
    logic        exp_wr [8];
    exp_ph = '{14'h0000, 14'h1000, 14'h2000, 14'h3000,
               14'h0000, 14'h1000, 14'h2000, 14'h3000};
    exp_wr = '{1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    load_now(24'h400000);
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (phase !== exp_ph[i] || wrap !== exp_wr[i]) begin
        fails++;
        $display("FAIL big_seq%0d got %h/%b exp %h/%b",
                 i, phase, wrap, exp_ph[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_sync_update();
    do_reset();
    en = 1'b1;
    load_now(24'h400000);
    tick();
    ftw_in = 24'h200000; ftw_valid = 1'b1; sync_mode = 1'b1;
    tick();
    ftw_valid = 1'b0;
    tests++;
    if (ftw_ready !== 1'b0 || phase !== 14'h1000) begin
      fails++;
      $display("FAIL sync_pend1 got %b/%h exp 0/1000",
               ftw_ready, phase);
    end
    tick();
    tests++;
    if (ftw_ready !== 1'b0 || phase !== 14'h2000) begin
      fails++;
      $display("FAIL sync_pend2 got %b/%h exp 0/2000",
               ftw_ready, phase);
    end
    tick();
    tests++;
    if (ftw_ready !== 1'b1 || wrap !== 1'b1
        || phase !== 14'h3000) begin
      fails++;
      $display("FAIL sync_xfer got %b/%b/%h exp 1/1/3000",
               ftw_ready, wrap, phase);
    end
    tick();
    tests++;
    if (phase !== 14'h0000) begin
      fails++;
      $display("FAIL sync_new0 got %h exp 0000", phase);
    end
    tick();
    tests++;
    if (phase !== 14'h0800) begin
      fails++;
      $display("FAIL sync_new1 got %h exp 0800", phase);
    end
    tick();
    tests++;
    if (phase !== 14'h1000) begin
      fails++;
      $display("FAIL sync_new2 got %h exp 1000", phase);
    end
  endtask

  task automatic test_poff();
    do_reset();
    en = 1'b1;
    poff = 14'h2000;
    tick();
    tick();
    tests++;
    if (phase !== 14'h2000 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL poff_const got %h/%b exp 2000/0",
               phase, wrap);
    end
    poff = 14'h0000;
    load_now(24'h000400);
    tick();
    en = 1'b0;
    poff = 14'h3FFF;
    tick();
    tests++;
    if (phase !== 14'h0000) begin
      fails++;
      $display("FAIL poff_modulo got %h exp 0000", phase);
    end
    tick();
    tests++;
    if (phase !== 14'h0000 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL poff_en_hold got %h/%b exp 0000/0",
               phase, wrap);
    end
  endtask

  task automatic test_clr_pend();
    do_reset();
    en = 1'b1;
    load_now(24'h400000);
    tick();
    ftw_in = 24'h100000; ftw_valid = 1'b1; sync_mode = 1'b1;
    tick();
    ftw_valid = 1'b0;
    tick();
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    tests++;
    if (wrap !== 1'b0 || ftw_ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_carry got %b/%b exp 0/0",
               wrap, ftw_ready);
    end
    tick();
    tests++;
    if (phase !== 14'h0000 || ftw_ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_acc got %h/%b exp 0000/0",
               phase, ftw_ready);
    end
    tick();
    tick();
    tick();
    tests++;
    if (wrap !== 1'b1 || ftw_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_next_wrap got %b/%b exp 1/1",
               wrap, ftw_ready);
    end
    tick();
    tick();
    tests++;
    if (phase !== 14'h0400) begin
      fails++;
      $display("FAIL clr_new_ftw got %h exp 0400", phase);
    end
  endtask

  task automatic test_rst_pend();
    do_reset();
    en = 1'b1;
    load_now(24'h400000);
    tick();
    ftw_in = 24'h100000; ftw_valid = 1'b1; sync_mode = 1'b1;
    tick();
    ftw_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (phase !== 14'h0 || ftw_ready !== 1'b1
        || wrap !== 1'b0) begin
      fails++;
      $display("FAIL rst_pend got %h/%b/%b exp 0000/1/0",
               phase, ftw_ready, wrap);
    end
    sync_mode = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (phase !== 14'h0 || wrap !== 1'b0
        || ftw_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_discard got %h/%b/%b exp 0000/0/1",
               phase, wrap, ftw_ready);
    end
  endtask

  initial begin
    test_reset();
    test_small_ftw();
    test_big_ftw();
    test_sync_update();
    test_poff();
    test_clr_pend();
    test_rst_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
